dac_serial_loader: RTL and testbench

DAC_SERIAL_LOADER -- requirements
Module: dac_serial_loader

---
 rtl/dac_pkg.sv | 13 +
 rtl/sync_ff.sv | 23 ++
 rtl/dac_serial_loader.sv | 135 +++++++++++++
 tb/tb_dac_serial_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants and FSM encoding for the serial DAC loader.
// Pure declarations: no logic, no latency, no flow control.
package dac_pkg;
    localparam int DAC_WIDTH       = 10;
    localparam int DAC_RESET_VAL   = 0;
    localparam int DAC_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } dac_state_t;
endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit; reset level chosen by the instantiator.
// Latency STAGES clk; no backpressure.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{i_rst_val}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/dac_serial_loader.sv
// Captures MSB-first serial frames from an asynchronous host and loads a parallel DAC code.
// Output changes SYNC_STAGES+2 clk after cs_n rises; host cannot be stalled, bad frames pulse frame_err.
module dac_serial_loader
    import dac_pkg::*;
#(
    parameter int               WIDTH       = DAC_WIDTH,
    parameter int               SYNC_STAGES = DAC_SYNC_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL   = WIDTH'(DAC_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             sdi,
    input  logic             cs_n,
    output logic [WIDTH-1:0] dac_val,
    output logic             dac_update,
    output logic             frame_err,
    output logic             busy
);
    localparam int               CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic w_sclk_s;
    logic w_sdi_s;
    logic w_cs_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk(clk), .i_rst_n(rst_n), .i_rst_val(1'b0), .i_d(sclk), .o_q(w_sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .i_clk(clk), .i_rst_n(rst_n), .i_rst_val(1'b0), .i_d(sdi), .o_q(w_sdi_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk(clk), .i_rst_n(rst_n), .i_rst_val(1'b1), .i_d(cs_n), .o_q(w_cs_s)
    );

    logic r_sclk_d;
    logic r_cs_d;
    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

    dac_state_t       r_state;
    dac_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_dac_val;
    logic [WIDTH-1:0] w_dac_val_nxt;
    logic             r_dac_update;
    logic             w_dac_update_nxt;
    logic             r_frame_err;
    logic             w_frame_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_dac_val    <= RESET_VAL;
            r_dac_update <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dac_val    <= w_dac_val_nxt;
            r_dac_update <= w_dac_update_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_cnt;
        w_dac_val_nxt    = r_dac_val;
        w_dac_update_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                // Only a fresh falling edge starts a frame; a cs_n already low is ignored.
                if (w_cs_fall) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                // End of frame wins over a coincident sclk edge; that bit is dropped.
                if (w_cs_rise) begin
                    w_state_nxt = DONE;
                end else if (w_sclk_rise) begin
                    w_shift_nxt = {r_shift[WIDTH-2:0], w_sdi_s};
                    if (r_cnt != CNT_SAT) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                if (r_cnt == CNT_FULL) begin
                    w_dac_val_nxt    = r_shift;
                    w_dac_update_nxt = 1'b1;
                end else begin
                    w_frame_err_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign dac_val    = r_dac_val;
    assign dac_update = r_dac_update;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state == SHIFT);
endmodule

// File: tb/tb_dac_serial_loader.sv
// Scoreboard bench for dac_serial_loader: host frames queue expected events, a monitor pops them.
// Clock 10 ns; host half-periods are 4 clk.
module tb_dac_serial_loader;
    localparam int W  = 10;
    localparam int SS = 2;
    localparam int HP = 4;

    logic         clk;
    logic         rst_n;
    logic         sclk;
    logic         sdi;
    logic         cs_n;
    logic [W-1:0] dac_val;
    logic         dac_update;
    logic         frame_err;
    logic         busy;

    dac_serial_loader #(
        .WIDTH(W), .SYNC_STAGES(SS), .RESET_VAL(10'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs_n(cs_n),
        .dac_val(dac_val), .dac_update(dac_update), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] val;
    } ev_t;

    ev_t          q[$];
    int           n_total = 0;
    int           n_bad   = 0;
    int           n_upd   = 0;
    int           n_err   = 0;
    int           cyc     = 0;
    int           rise_cyc = 0;
    logic [W-1:0] exp_val = '0;
    logic [W-1:0] prev_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (dac_update === 1'b1 || frame_err === 1'b1) begin
            chk("evt_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("evt_err", 32'(frame_err), 32'(e.is_err));
                chk("evt_upd", 32'(dac_update), 32'(!e.is_err));
                chk("evt_val", 32'(dac_val), 32'(e.val));
                chk("evt_lat", 32'(cyc - rise_cyc), 32'(SS + 2));
            end
            if (dac_update === 1'b1) n_upd++;
            if (frame_err === 1'b1) n_err++;
        end
        if (rst_n === 1'b1 && dac_update !== 1'b1 && dac_val !== prev_val)
            chk("val_stable", 32'(dac_val), 32'(prev_val));
        prev_val = dac_val;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits, input bit coinc);
        cs_n = 1'b0;
        wait_clk(HP);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi  = bits[i];
            sclk = 1'b0;
            wait_clk(HP);
            sclk = 1'b1;
            wait_clk(HP);
            if (i == nbits - 3) chk("busy_mid", 32'(busy), 32'd1);
        end
        sclk = 1'b0;
        if (coinc) begin
            sdi = 1'b1;
            wait_clk(HP);
            sclk     = 1'b1;
            cs_n     = 1'b1;
            rise_cyc = cyc;
            wait_clk(HP);
            sclk = 1'b0;
        end else begin
            wait_clk(HP);
            cs_n     = 1'b1;
            rise_cyc = cyc;
        end
        wait_clk(SS + 3);
        chk("busy_gap", 32'(busy), 32'd0);
        sdi = 1'b0;
    endtask

    task automatic frame_ok(input logic [W-1:0] v, input bit coinc);
        q.push_back('{is_err: 1'b0, val: v});
        exp_val = v;
        send_frame(32'(v), W, coinc);
    endtask

    task automatic frame_bad(input logic [31:0] bits, input int nbits);
        q.push_back('{is_err: 1'b1, val: exp_val});
        send_frame(bits, nbits, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_val"}, 32'(dac_val), 32'd0);
        chk({tag, "_upd"}, 32'(dac_update), 32'd0);
        chk({tag, "_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b1;
        sclk  = 1'b0;
        sdi   = 1'b0;
        cs_n  = 1'b1;
        #1 rst_n = 1'b0;
        wait_clk(3);
        chk_reset_outputs("rst0");
        rst_n = 1'b1;
        wait_clk(3);

        frame_ok(10'd50, 1'b0);
        frame_ok(10'd200, 1'b0);
        frame_ok(10'd150, 1'b0);
        frame_bad(32'h55, 7);
        frame_bad(32'h5A5, 11);
        frame_bad(32'h2AAAAAA, 26);
        frame_ok(10'h2B3, 1'b1);

        // sclk/sdi wiggling with cs_n high must produce nothing
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1;
            sdi  = ~sdi;
            wait_clk(HP);
            sclk = 1'b0;
            wait_clk(HP);
        end
        wait_clk(8);

        // abandon a frame after 5 bits by pulsing reset
        cs_n = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < 5; i++) begin
            sdi  = 1'b1;
            sclk = 1'b0;
            wait_clk(HP);
            sclk = 1'b1;
            wait_clk(HP);
        end
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        sdi   = 1'b0;
        wait_clk(2);
        chk_reset_outputs("rst1");
        exp_val = '0;
        rst_n   = 1'b1;
        wait_clk(6);
        chk("post_rst_busy", 32'(busy), 32'd0);
        frame_ok(10'd10, 1'b0);

        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            wait_clk(1);
            guard++;
        end
        wait_clk(4);
        chk("drain", 32'(q.size()), 32'd0);
        chk("n_upd", 32'(n_upd), 32'd5);
        chk("n_err", 32'(n_err), 32'd3);
        chk("final_val", 32'(dac_val), 32'd10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
